fetch_prefetch_buf: RTL and testbench

// - Synthesizable fetch stage driving the F->D interface (val/rdy, pc, inst, squash, branch_target).
// - Issues sequential PC requests to instruction memory and queues in-order responses in a p_depth FIFO.
// - On squash: flushes the FIFO, redirects the PC and discards stale in-flight responses.
// - Sits between the icache/memory port and decode.

---
 rtl/fetch_prefetch_buf.sv | 126 ++++++++++++
 tb/tb_fetch_prefetch_buf.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_buf.sv
`default_nettype none
// fetch_prefetch_buf: sequential-PC fetch stage with an in-order prefetch FIFO toward decode.
// Optional FETCH_PREFETCH_BYPASS_EN: zero-latency response bypass when the FIFO is empty.
module fetch_prefetch_buf #(
    parameter int unsigned          p_addr_bits = 32,
    parameter int unsigned          p_inst_bits = 32,
    parameter int unsigned          p_depth     = 4,
    parameter logic [p_addr_bits-1:0] p_rst_addr = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    output logic [p_addr_bits-1:0] mem_req_addr,
    input  logic                   mem_resp_val,
    input  logic [p_inst_bits-1:0] mem_resp_data,
    output logic                   d_val,
    input  logic                   d_rdy,
    output logic [p_addr_bits-1:0] d_pc,
    output logic [p_inst_bits-1:0] d_inst,
    input  logic                   squash,
    input  logic [p_addr_bits-1:0] branch_target
);
    localparam int unsigned PW = $clog2(p_depth);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(p_depth);

    logic [p_addr_bits-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]          inflight_q, inflight_d;
    logic [CW-1:0]          drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

    logic [p_addr_bits-1:0] tag_mem_q  [p_depth];
    logic [p_addr_bits-1:0] pc_mem_q   [p_depth];
    logic [p_inst_bits-1:0] inst_mem_q [p_depth];

    logic req_fire, empty, resp_keep, resp_drop, bypass, deq_fire, push, pop;

    assign mem_req_val  = rst & ~squash & (({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_W);
    assign mem_req_addr = fetch_pc_q;
    assign req_fire     = mem_req_val & mem_req_rdy;
    assign empty        = (count_q == '0);
    assign resp_keep    = mem_resp_val & ~squash & (drop_cnt_q == '0);
    assign resp_drop    = mem_resp_val & ~squash & (drop_cnt_q != '0);

`ifdef FETCH_PREFETCH_BYPASS_EN
    assign bypass = rst & empty & (drop_cnt_q == '0) & mem_resp_val;
`else
    assign bypass = 1'b0;
`endif

    assign d_val    = ~empty | bypass;
    assign d_pc     = ~empty ? pc_mem_q[rd_ptr_q]   : (bypass ? tag_mem_q[tag_rd_q] : '0);
    assign d_inst   = ~empty ? inst_mem_q[rd_ptr_q] : (bypass ? mem_resp_data       : '0);
    assign deq_fire = d_val & d_rdy & ~squash;
    // A bypassed response consumed in the same cycle never occupies a FIFO slot.
    assign push     = resp_keep & ~(bypass & d_rdy);
    assign pop      = deq_fire & ~empty;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        if (squash) begin
            // Everything still outstanding is stale; a response landing now is already discarded.
            fetch_pc_d = branch_target;
            inflight_d = inflight_q - CW'(mem_resp_val);
            drop_cnt_d = inflight_q - CW'(mem_resp_val);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + p_addr_bits'(4);
                tag_wr_d   = tag_wr_q + PW'(1);
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(mem_resp_val);
            if (resp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
            if (resp_keep) tag_rd_d = tag_rd_q + PW'(1);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= p_rst_addr;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) tag_mem_q[tag_wr_q] <= fetch_pc_q;
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= tag_mem_q[tag_rd_q];
            inst_mem_q[wr_ptr_q] <= mem_resp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_buf.sv
`default_nettype none
// tb_fetch_prefetch_buf: scoreboard bench with a fixed-latency in-order memory model.
module tb_fetch_prefetch_buf;
    localparam logic [31:0] RST_ADDR = 32'h200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req_val, mem_req_rdy = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_val = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        d_val, d_rdy = 1'b0;
    logic [31:0] d_pc, d_inst;
    logic        squash = 1'b0;
    logic [31:0] branch_target = '0;

    fetch_prefetch_buf #(
        .p_addr_bits(32), .p_inst_bits(32), .p_depth(4), .p_rst_addr(RST_ADDR)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
        .d_val(d_val), .d_rdy(d_rdy), .d_pc(d_pc), .d_inst(d_inst),
        .squash(squash), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    mreq_t       memq[$];
    logic [63:0] sb[$];
    int unsigned cyc = 0, lat = 1, nfire = 0, ndeq = 0;
    int          checks = 0, errors = 0;
    logic        req_rdy_b = 1'b0, d_rdy_b = 1'b0;
    logic [31:0] exp_pc = RST_ADDR, last_pc = '0, sq_tgt = '0;
    logic        have_last = 1'b0, first_after_sq = 1'b0, s_dval = 1'b0, s_resp = 1'b0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEADBEEF;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: present memory response and controls, sample, update models.
    task automatic step(input logic sq, input logic [31:0] tgt);
        logic [63:0] e;
        @(negedge clk);
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            mem_resp_val  = 1'b1;
            mem_resp_data = mem_data(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            mem_resp_val  = 1'b0;
            mem_resp_data = $urandom;
        end
        squash        = sq;
        branch_target = tgt;
        d_rdy         = d_rdy_b;
        mem_req_rdy   = req_rdy_b;
        #1;
        s_dval = d_val;
        s_resp = mem_resp_val;
        if (sq) check_eq("squash_no_req", {63'd0, mem_req_val}, 64'd0);
        if (mem_req_val && mem_req_rdy) begin
            check_eq("req_addr", {32'd0, mem_req_addr}, {32'd0, exp_pc});
            memq.push_back('{addr: mem_req_addr, due: cyc + lat});
            sb.push_back({exp_pc, mem_data(exp_pc)});
            exp_pc += 32'd4;
            nfire++;
        end
        if (d_val && d_rdy && !sq) begin
            ndeq++;
            if (sb.size() == 0) begin
                check_eq("spurious_deq", {32'd0, d_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check_eq("d_pc", {32'd0, d_pc}, {32'd0, e[63:32]});
                check_eq("d_inst", {32'd0, d_inst}, {32'd0, e[31:0]});
            end
            if (have_last) check_eq("pc_step", {32'd0, d_pc}, {32'd0, last_pc + 32'd4});
            if (first_after_sq) check_eq("sq_first_pc", {32'd0, d_pc}, {32'd0, sq_tgt});
            first_after_sq = 1'b0;
            last_pc   = d_pc;
            have_last = 1'b1;
        end
        if (sq) begin
            sb.delete();
            exp_pc         = tgt;
            sq_tgt         = tgt;
            have_last      = 1'b0;
            first_after_sq = 1'b1;
        end
        cyc++;
    endtask

    // Stop issuing and let all outstanding work retire, bounded.
    task automatic drain();
        int n;
        req_rdy_b = 1'b0;
        d_rdy_b   = 1'b1;
        n = 0;
        while ((sb.size() != 0 || memq.size() != 0 || s_dval) && n < 60) begin
            step(1'b0, '0);
            n++;
        end
        check_eq("drain", {32'd0, sb.size()} + {32'd0, memq.size()}, 64'd0);
    endtask

    initial begin
        int unsigned n0, d0;
        logic [31:0] lat_pc;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req_val", {63'd0, mem_req_val}, 64'd0);
        check_eq("rst_d_val", {63'd0, d_val}, 64'd0);
        check_eq("rst_d_pc", {32'd0, d_pc}, 64'd0);
        check_eq("rst_d_inst", {32'd0, d_inst}, 64'd0);
        check_eq("rst_addr", {32'd0, mem_req_addr}, {32'd0, RST_ADDR});
        @(negedge clk);
        rst = 1'b1;

        // Streaming with a 1-cycle memory.
        lat = 1; req_rdy_b = 1'b1; d_rdy_b = 1'b1;
        repeat (20) step(1'b0, '0);
        drain();

        // Decode stalled: only p_depth requests may be issued.
        req_rdy_b = 1'b1; d_rdy_b = 1'b0; n0 = nfire;
        repeat (10) step(1'b0, '0);
        check_eq("stall_fires", 64'(nfire - n0), 64'd4);
        check_eq("stall_req_val", {63'd0, mem_req_val}, 64'd0);
        d_rdy_b = 1'b1; n0 = nfire; d0 = ndeq;
        repeat (12) step(1'b0, '0);
        check_eq("resume_issue", {63'd0, (nfire - n0) > 0}, 64'd1);
        check_eq("resume_drain", {63'd0, (ndeq - d0) >= 4}, 64'd1);
        drain();

        // Squash with exactly three requests in flight.
        lat = 4; req_rdy_b = 1'b1; d_rdy_b = 1'b1; n0 = nfire;
        repeat (3) step(1'b0, '0);
        check_eq("three_inflight", 64'(nfire - n0), 64'd3);
        step(1'b1, 32'h1000);
        step(1'b0, '0);
        check_eq("sq_fifo_empty", {63'd0, d_val}, 64'd0);
        check_eq("sq_next_addr", {32'd0, mem_req_addr}, 64'h1000);
        repeat (10) step(1'b0, '0);
        drain();

        // Squash coinciding with a dequeue and a response (2-cycle memory).
        lat = 2; req_rdy_b = 1'b1; d_rdy_b = 1'b1;
        repeat (6) step(1'b0, '0);
        step(1'b1, 32'h2000);
        check_eq("sq_coincide", {62'd0, s_dval, s_resp}, 64'd3);
        step(1'b0, '0);
        check_eq("sq2_fifo_empty", {63'd0, d_val}, 64'd0);
        repeat (10) step(1'b0, '0);
        drain();

        // Random decode back-pressure, 1-cycle memory.
        lat = 1; req_rdy_b = 1'b1;
        for (int i = 0; i < 30; i++) begin
            d_rdy_b = ($urandom_range(0, 3) != 0);
            step(1'b0, '0);
        end
        drain();

        // Single response into an empty FIFO: latency to d_val.
        lat = 1; d_rdy_b = 1'b1; req_rdy_b = 1'b1; lat_pc = exp_pc;
        step(1'b0, '0);
        req_rdy_b = 1'b0;
        step(1'b0, '0);
`ifdef FETCH_PREFETCH_BYPASS_EN
        check_eq("lat_t_val", {63'd0, d_val}, 64'd1);
        check_eq("lat_t_inst", {32'd0, d_inst}, {32'd0, mem_data(lat_pc)});
        step(1'b0, '0);
        check_eq("lat_t1_val", {63'd0, d_val}, 64'd0);
`else
        check_eq("lat_t_val", {63'd0, d_val}, 64'd0);
        step(1'b0, '0);
        check_eq("lat_t1_val", {63'd0, d_val}, 64'd1);
        check_eq("lat_t1_inst", {32'd0, d_inst}, {32'd0, mem_data(lat_pc)});
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
